ir_grid_scanner: RTL and testbench
==================================

# ir_grid_scanner

Scans the 4x4 IR sensor matrix under the play surface and produces the debounced 16-bit cell vector `ir_out` that feeds the `ir_in` input of the box-colouring VGA block. It is the producer side of that interface. Bit `r*4+c` is grid row `r`, column `c`, so bits 0–3 are the top row and bits 12–15 are the bottom row. The block drives one sensor row at a time, samples the four column sense lines, and debounces each cell across frames. It can optionally latch cells that have been traced.

## Interface
- `SCAN_DIV`, default 1024: clk cycles each row is driven (dwell); legal values ≥ 2.
- `DEBOUNCE`, default 3: consecutive disagreeing samples needed to flip a cell; legal range 1–7.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `clear`  input  1  one-cycle pulse; clears traced cells. Only has an effect with `IR_STICKY_TRACE_EN`.
- `ir_row_drive`  output  4  one-hot, active-high drive for the current sensor row.
- `ir_col_sense`  input  4  raw column returns, 1 = beam broken; already synchronised upstream.
- `ir_out`  output  16  debounced (or traced) cell state; connects to `ir_in`.
- `frame_done`  output  1  one-cycle pulse when a full 4-row scan has been committed.
- `active_count`  output  5  registered popcount of `ir_out`, range 0–16.

## Operation
- **Scan counters:**
  - `row` is 2-bit; `dwell` counts 0..SCAN_DIV-1.
  - `ir_row_drive` = 1 << `row`.
  - At `dwell == SCAN_DIV-1` (the sample cycle): sample `ir_col_sense[c]` into cell `row*4+c`, set `dwell` ← 0, and set `row` ← `row+1`, wrapping from 3 to 0.
  - Every other cycle: `dwell` ← `dwell+1`.
- **Per-cell debounce** (16 × 3-bit counters `cnt`, 16-bit `stable`), evaluated only for the four cells of the sampled row:
  - raw == `stable[i]` → `cnt[i]` ← 0.
  - raw != `stable[i]` and `cnt[i]+1 == DEBOUNCE` → `stable[i]` flips, `cnt[i]` ← 0.
  - otherwise → `cnt[i]` ← `cnt[i]+1`.
  - A bouncing input that returns to the stable value resets the count.
- **Unsampled rows:** cells of other rows hold their state.
- **`ir_out`:** registered from `stable`, or from `traced` when `IR_STICKY_TRACE_EN` is defined (see Configuration).
- **`frame_done`:** asserted for the one cycle following the row-3 sample edge.
- **`active_count`:** popcount of the next `ir_out`, registered on the same edge that updates `ir_out`.

## Timing
- **Reset:** on the edge where `reset` is high, the block loads `row`=0, `dwell`=0, `ir_row_drive`=4'b0001, `stable`=0, all `cnt`=0, `traced`=0, `ir_out`=16'h0000, `frame_done`=0, `active_count`=0.
  - Reset asserted mid-frame abandons the scan; the block restarts at row 0 on the cycle after reset deasserts.
  - `reset` has priority over `clear`.
- **Frame period:** 4·SCAN_DIV cycles. Row `r` is sampled at cycle `r·SCAN_DIV + SCAN_DIV-1` after reset deasserts.
- **Sample latency:** `ir_out` reflects a sample one cycle after the sample edge.
- **Debounce latency:** a cell held constantly at the opposite value flips after exactly DEBOUNCE samples, i.e. on the DEBOUNCE-th frame. With DEBOUNCE=1, every sample flips immediately.
- **Row drive:** `ir_row_drive` changes on the sample edge. The sensor settle time is absorbed by the dwell.

## Configuration
- **Macro:** `IR_STICKY_TRACE_EN`.
- **Defined:**
  - A 16-bit `traced` register is updated as `traced[i]` ← `traced[i] | stable_next[i]`, and `ir_out` = `traced`.
  - A traced cell stays set after the wand leaves it.
  - `clear` zeroes `traced` on its edge and wins over a same-edge set; that cell re-sets on its next sample, provided it is still stable-high.
- **Not defined:**
  - `ir_out` = `stable`; cells drop when their debounced state falls.
  - `clear` is ignored.
  - No `traced` storage is built.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, giving a 16-cycle frame.
- **Reset:** hold `reset` 3 cycles, then release → `ir_row_drive` = 0001, 0010, 0100, 1000 for 4 cycles each; `frame_done` is high only at cycles 16, 32, …; `ir_out` = 0.
- **Debounce rise:** drive `ir_col_sense`=4'b0100 only while row 1 is driven → `ir_out` = 16'h0040 one cycle after the third row-1 sample (cycle 3·16−16+8 = 40); `active_count` = 1.
- **Glitch rejection:** cell 5 is high for 2 frames, low for 1 frame, then high for 2 frames → `ir_out[5]` never sets.
- **Release without macro:** after setting cell 0, hold it low for 3 frames → `ir_out` returns to 0.
- **Sticky with macro:** after the release above, `ir_out[0]` stays 1; pulse `clear` → `ir_out` = 0 the next cycle and stays 0.
- **Mid-frame reset:** assert `reset` at cycle 21 → next cycle shows `ir_row_drive`=0001, `ir_out`=0, `frame_done`=0, and partial debounce counts are discarded (a cell then needs 3 full frames to set).

Source files
------------

// File: rtl/ir_grid_scanner.sv
// 4x4 IR sensor matrix scanner: drives one row per dwell, debounces each cell across frames.
// Optional build macro IR_STICKY_TRACE_EN latches cells that have been traced until `clear`.
module ir_grid_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic [3:0]  ir_row_drive,
  input  logic [3:0]  ir_col_sense,
  output logic [15:0] ir_out,
  output logic        frame_done,
  output logic [4:0]  active_count
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell;
  logic [1:0]    row;
  logic          sample;
  logic [2:0]    cnt      [16];
  logic [2:0]    cnt_next [16];
  logic [15:0]   stable, stable_next, out_next;
  logic [4:0]    pop_next;

  always_comb sample = (dwell == DW'(SCAN_DIV - 1));
  always_comb ir_row_drive = 4'b0001 << row;

  // Only the four cells of the row being sampled are evaluated; the rest hold.
  always_comb begin
    stable_next = stable;
    cnt_next    = cnt;
    for (int unsigned i = 0; i < 16; i++) begin
      if (sample && (2'(i >> 2) == row)) begin
        if (ir_col_sense[2'(i & 3)] == stable[i]) begin
          cnt_next[i] = '0;
        end else if (({1'b0, cnt[i]} + 4'd1) == 4'(DEBOUNCE)) begin
          stable_next[i] = ~stable[i];
          cnt_next[i]    = '0;
        end else begin
          cnt_next[i] = cnt[i] + 3'd1;
        end
      end
    end
  end

`ifdef IR_STICKY_TRACE_EN
  logic [15:0] traced, traced_next, row_mask;

  // A cell traces on its own sample; clear wins over a same-edge set.
  always_comb begin
    row_mask    = 16'h000F << {row, 2'b00};
    traced_next = traced;
    if (sample) traced_next = traced | (stable_next & row_mask);
    if (clear)  traced_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) traced <= '0;
    else       traced <= traced_next;
  end

  always_comb out_next = traced_next;
`else
  logic unused_clear;
  always_comb unused_clear = clear;
  always_comb out_next = stable_next;
`endif

  always_comb begin
    pop_next = '0;
    for (int unsigned i = 0; i < 16; i++) pop_next = pop_next + 5'(out_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row          <= '0;
      dwell        <= '0;
      stable       <= '0;
      ir_out       <= '0;
      frame_done   <= 1'b0;
      active_count <= '0;
      for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      if (sample) begin
        dwell <= '0;
        row   <= row + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end
      stable       <= stable_next;
      cnt          <= cnt_next;
      ir_out       <= out_next;
      frame_done   <= sample && (row == 2'd3);
      active_count <= pop_next;
    end
  end

endmodule

// File: tb/tb_ir_grid_scanner.sv
// Self-checking bench for ir_grid_scanner (SCAN_DIV=4, DEBOUNCE=3, 16-cycle frame).
// Reference model is cycle-count based: row and sample instants derived from time since reset.
module tb_ir_grid_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  ir_col_sense = 4'h0;
  logic [3:0]  ir_row_drive;
  logic [15:0] ir_out;
  logic        frame_done;
  logic [4:0]  active_count;

  int checks = 0;
  int errors = 0;

  ir_grid_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .ir_row_drive(ir_row_drive), .ir_col_sense(ir_col_sense),
    .ir_out(ir_out), .frame_done(frame_done), .active_count(active_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_t;
  logic [15:0] m_stable, m_traced, m_out;
  int          m_cnt [16];
  logic        m_fd;
  int          m_pop;
  logic [15:0] grid;   // cells currently blocked by the wand

  function automatic logic [3:0] exp_drive();
    return 4'b0001 << ((m_t / SD) % 4);
  endfunction

  function automatic logic [3:0] cur_cols();
    logic [15:0] s;
    s = grid >> (4 * ((m_t / SD) % 4));
    return s[3:0];
  endfunction

  task automatic step(input logic rst, input logic clr);
    int r;
    int i;
    logic smp;
    reset = rst;
    clear = clr;
    ir_col_sense = cur_cols();
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_stable = '0; m_traced = '0; m_fd = 1'b0;
      for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    end else begin
      r = (m_t / SD) % 4;
      smp = ((m_t % SD) == SD - 1);
      if (smp) begin
        for (int c = 0; c < 4; c++) begin
          i = r * 4 + c;
          if (ir_col_sense[c] == m_stable[i]) m_cnt[i] = 0;
          else if (m_cnt[i] + 1 >= DB) begin
            m_stable[i] = ~m_stable[i];
            m_cnt[i] = 0;
          end else m_cnt[i]++;
          if (m_stable[i]) m_traced[i] = 1'b1;
        end
      end
      if (clr) m_traced = '0;
      m_fd = smp && (r == 3);
      m_t++;
    end
`ifdef IR_STICKY_TRACE_EN
    m_out = m_traced;
`else
    m_out = m_stable;
`endif
    m_pop = $countones(m_out);
    #1;
  endtask

  task automatic test_reset();
    grid = '0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({ir_row_drive, ir_out, frame_done, active_count} !== {4'b0001, 16'h0000, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL reset_state: drive=%b out=%h fd=%b cnt=%0d, required drive=0001 out=0000 fd=0 cnt=0",
                 ir_row_drive, ir_out, frame_done, active_count);
      end
    end
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b0);
      checks++;
      if (ir_row_drive !== (4'b0001 << (((k) / 4) % 4)) || frame_done !== ((k % 16) == 0) || ir_out !== 16'h0) begin
        errors++;
        $display("FAIL reset_scan cycle %0d: drive=%b fd=%b out=%h, required drive=%b fd=%b out=0000",
                 k, ir_row_drive, frame_done, ir_out, 4'b0001 << ((k / 4) % 4), (k % 16) == 0);
      end
    end
  endtask

  task automatic test_debounce_rise();
    grid = '0;
    step(1'b1, 1'b0);
    grid = 16'h0040;
    while (m_t < 40) begin
      step(1'b0, 1'b0);
      checks++;
      if ({ir_row_drive, ir_out, frame_done, active_count} !== {exp_drive(), m_out, m_fd, 5'(m_pop)}) begin
        errors++;
        $display("FAIL debounce_rise t=%0d: drive=%b out=%h fd=%b cnt=%0d, required %b %h %b %0d",
                 m_t, ir_row_drive, ir_out, frame_done, active_count, exp_drive(), m_out, m_fd, m_pop);
      end
      if (m_t == 39) begin
        checks++;
        if (ir_out !== 16'h0000) begin
          errors++;
          $display("FAIL debounce_early: out=%h, required 0000", ir_out);
        end
      end
    end
    checks++;
    if (ir_out !== 16'h0040 || active_count !== 5'd1) begin
      errors++;
      $display("FAIL debounce_set_at_40: out=%h cnt=%0d, required 0040 1", ir_out, active_count);
    end
  endtask

  task automatic test_glitch_rejection();
    grid = '0;
    step(1'b1, 1'b0);
    while (m_t < 80) begin
      grid = ((m_t / 16) == 2) ? 16'h0000 : 16'h0020;
      step(1'b0, 1'b0);
      checks++;
      if (ir_out[5] !== 1'b0 || ir_out !== m_out) begin
        errors++;
        $display("FAIL glitch t=%0d: out=%h, required %h with bit5=0", m_t, ir_out, m_out);
      end
    end
  endtask

  task automatic test_release_and_sticky();
    grid = '0;
    step(1'b1, 1'b0);
    grid = 16'h0001;
    repeat (48) step(1'b0, 1'b0);
    checks++;
    if (ir_out !== 16'h0001) begin
      errors++;
      $display("FAIL release_set: out=%h, required 0001", ir_out);
    end
    grid = '0;
    repeat (48) step(1'b0, 1'b0);
    checks++;
`ifdef IR_STICKY_TRACE_EN
    if (ir_out !== 16'h0001) begin
      errors++;
      $display("FAIL sticky_hold: out=%h, required 0001", ir_out);
    end
`else
    if (ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL release_drop: out=%h, required 0000", ir_out);
    end
`endif
    step(1'b0, 1'b1);
    checks++;
    if (ir_out !== 16'h0000 || active_count !== 5'd0) begin
      errors++;
      $display("FAIL clear_pulse: out=%h cnt=%0d, required 0000 0", ir_out, active_count);
    end
    repeat (20) begin
      step(1'b0, 1'b0);
      checks++;
      if (ir_out !== 16'h0000) begin
        errors++;
        $display("FAIL clear_stays: out=%h, required 0000", ir_out);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    grid = '0;
    step(1'b1, 1'b0);
    grid = 16'h0001;
    repeat (21) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({ir_row_drive, ir_out, frame_done} !== {4'b0001, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: drive=%b out=%h fd=%b, required 0001 0000 0",
               ir_row_drive, ir_out, frame_done);
    end
    while (m_t < 36) begin
      step(1'b0, 1'b0);
      checks++;
      if (ir_out[0] !== (m_t >= 36)) begin
        errors++;
        $display("FAIL midframe_recount t=%0d: out0=%b, required %b", m_t, ir_out[0], m_t >= 36);
      end
    end
  endtask

  task automatic test_random();
    grid = '0;
    step(1'b1, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      if ((m_t % 16) == 0 && $urandom_range(1, 0) == 1) grid = 16'($urandom);
      step(($urandom_range(299, 0) == 0), ($urandom_range(39, 0) == 0));
      checks++;
      if ({ir_row_drive, ir_out, frame_done, active_count} !== {exp_drive(), m_out, m_fd, 5'(m_pop)}) begin
        errors++;
        $display("FAIL random k=%0d: drive=%b out=%h fd=%b cnt=%0d, required %b %h %b %0d",
                 k, ir_row_drive, ir_out, frame_done, active_count, exp_drive(), m_out, m_fd, m_pop);
      end
    end
  endtask

  initial begin
    m_t = 0; m_stable = '0; m_traced = '0; m_out = '0; m_fd = 1'b0; m_pop = 0; grid = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    #2;
    test_reset();
    test_debounce_rise();
    test_glitch_rejection();
    test_release_and_sticky();
    test_mid_frame_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
